hilo_md_sequencer: RTL and testbench

//  Multi-cycle sequencer for the HI/LO multiply/divide unit of the pipelined MIPS core.

---
 rtl/hilo_md_sequencer_if.sv | 19 +
 rtl/hilo_md_sequencer.sv | 126 ++++++++++++
 tb/tb_hilo_md_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hilo_md_sequencer_if.sv
// Execute-stage <-> HI/LO multiply/divide sequencer handshake.
// master = pipeline side issuing ops, slave = sequencer.
interface hilo_md_sequencer_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cancel_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (output start_i, op_i, a_i, b_i, cancel_i,
                  input  stall_o, busy_o, done_o, hi_o, lo_o);
  modport slave  (input  start_i, op_i, a_i, b_i, cancel_i,
                  output stall_o, busy_o, done_o, hi_o, lo_o);
endinterface

// File: rtl/hilo_md_sequencer.sv
// HI/LO multiply/divide sequencer: MUL_LAT-cycle multiply or WIDTH-iteration
// restoring divide, stalling the pipeline until the result is committed.
module hilo_md_sequencer #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  hilo_md_sequencer_if.slave md
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, stateNxt;
  logic [5:0]       cnt;
  logic             sgnOp;
  logic [WIDTH-1:0] aReg, bReg;
  logic [WIDTH-1:0] quot, rem, dvs;
  logic [WIDTH-1:0] resHi, resLo;
  logic [WIDTH-1:0] outHi, outLo;

  logic accept, mulLast, divLast, commit;
  assign accept  = (state == IDLE) && md.start_i && !md.cancel_i;
  assign mulLast = (state == MUL) && (cnt == 6'(MUL_LAT - 1));
  assign divLast = (state == DIV) && (cnt == 6'(WIDTH - 1));
  assign commit  = (state == DONE) && !md.cancel_i;

  // Multiply: operands extended to 2W so the low 2W bits are the exact product.
  logic [2*WIDTH-1:0] extA, extB, prod;
  assign extA = sgnOp ? {{WIDTH{aReg[WIDTH-1]}}, aReg} : {{WIDTH{1'b0}}, aReg};
  assign extB = sgnOp ? {{WIDTH{bReg[WIDTH-1]}}, bReg} : {{WIDTH{1'b0}}, bReg};
  assign prod = extA * extB;

  // One restoring-division step on magnitudes; diff[WIDTH] set means borrow.
  logic [WIDTH:0]   shifted, diff;
  logic             qBit;
  logic [WIDTH-1:0] remNxt, quotNxt, divQ, divR;
  logic             aNeg, bNeg, bZero;
  assign shifted = {rem, quot[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign qBit    = !diff[WIDTH];
  assign remNxt  = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quotNxt = {quot[WIDTH-2:0], qBit};
  assign aNeg    = sgnOp && aReg[WIDTH-1];
  assign bNeg    = sgnOp && bReg[WIDTH-1];
  assign bZero   = (bReg == '0);
  assign divQ    = (aNeg ^ bNeg) ? -quotNxt : quotNxt;
  assign divR    = aNeg ? -remNxt : remNxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt   = state;
    md.stall_o = 1'b0;
    md.busy_o  = 1'b0;
    md.done_o  = commit;
    md.hi_o    = commit ? resHi : outHi;
    md.lo_o    = commit ? resLo : outLo;
    case (state)
      IDLE: begin
        md.stall_o = accept;
        if (accept) stateNxt = md.op_i[1] ? DIV : MUL;
      end
      MUL: begin
        md.stall_o = !md.cancel_i;
        md.busy_o  = 1'b1;
        if (md.cancel_i)   stateNxt = IDLE;
        else if (mulLast)  stateNxt = DONE;
      end
      DIV: begin
        md.stall_o = !md.cancel_i;
        md.busy_o  = 1'b1;
        if (md.cancel_i)   stateNxt = IDLE;
        else if (divLast)  stateNxt = DONE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      sgnOp <= 1'b0;
      aReg  <= '0;
      bReg  <= '0;
      quot  <= '0;
      rem   <= '0;
      dvs   <= '0;
      resHi <= '0;
      resLo <= '0;
      outHi <= '0;
      outLo <= '0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        sgnOp <= !md.op_i[0];
        aReg  <= md.a_i;
        bReg  <= md.b_i;
        rem   <= '0;
        quot  <= (!md.op_i[0] && md.a_i[WIDTH-1]) ? -md.a_i : md.a_i;
        dvs   <= (!md.op_i[0] && md.b_i[WIDTH-1]) ? -md.b_i : md.b_i;
      end
      if (state == MUL) cnt <= cnt + 6'd1;
      if (state == DIV) begin
        cnt  <= cnt + 6'd1;
        rem  <= remNxt;
        quot <= quotNxt;
      end
      if (mulLast && !md.cancel_i) begin
        resHi <= prod[2*WIDTH-1:WIDTH];
        resLo <= prod[WIDTH-1:0];
      end
      if (divLast && !md.cancel_i) begin
        resHi <= bZero ? aReg : divR;
        resLo <= bZero ? '1   : divQ;
      end
      // A cancel in DONE discards the pending result; outputs keep the old one.
      if (commit) begin
        outHi <= resHi;
        outLo <= resLo;
      end
    end
  end
endmodule

// File: tb/tb_hilo_md_sequencer.sv
// Directed bench for hilo_md_sequencer: cycle-level expectations from an
// arithmetic model plus literal result pins for the reference vectors.
module tb_hilo_md_sequencer;
  localparam int W  = 32;
  localparam int ML = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_md_sequencer_if #(.WIDTH(W)) md();
  hilo_md_sequencer #(.WIDTH(W), .MUL_LAT(ML)) dut (.clk(clk), .rst(rst), .md(md));

  int nChecks = 0;
  int nErrors = 0;
  bit chkEn = 1'b0;
  logic eStall, eDone, eBusy;
  logic [W-1:0] eHi, eLo, mHi, mLo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {hi, lo} per MIPS HI/LO semantics, using plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    logic [31:0] q, r;
    if (!op[1]) begin
      if (op[0]) p = longint'({32'b0, a}) * longint'({32'b0, b});
      else       p = longint'($signed(a)) * longint'($signed(b));
      return 64'(p);
    end
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (!op[0]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      sa = $signed(a); sb = $signed(b);
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  always @(negedge clk) begin
    if (chkEn) begin
      chk("stall", 64'(md.stall_o), 64'(eStall));
      chk("done",  64'(md.done_o),  64'(eDone));
      chk("busy",  64'(md.busy_o),  64'(eBusy));
      chk("hi",    64'(md.hi_o),    64'(eHi));
      chk("lo",    64'(md.lo_o),    64'(eLo));
    end
  end

  // Issue one op with start held through DONE; cycle k=0 is the IDLE issue cycle.
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int cancelAt, input bit tail, input bit pin,
                       input logic [31:0] pHi, input logic [31:0] pLo);
    logic [63:0] r;
    int lat;
    r   = model(op, a, b);
    lat = op[1] ? W : ML;
    md.op_i = op; md.a_i = a; md.b_i = b;
    for (int k = 0; k <= lat + 1; k++) begin
      md.start_i  = 1'b1;
      md.cancel_i = (k == cancelAt);
      eHi = mHi; eLo = mLo; eDone = 1'b0;
      if (k == cancelAt) begin
        eStall = 1'b0; eBusy = (k > 0);
      end else if (k <= lat) begin
        eStall = 1'b1; eBusy = (k > 0);
      end else begin
        eStall = 1'b0; eBusy = 1'b0; eDone = 1'b1;
        eHi = r[63:32]; eLo = r[31:0];
        if (pin) begin
          #2;
          chk("pinHi", 64'(md.hi_o), 64'(pHi));
          chk("pinLo", 64'(md.lo_o), 64'(pLo));
        end
      end
      @(posedge clk); #1;
      if (k == cancelAt) break;
    end
    if (cancelAt < 0) begin mHi = r[63:32]; mLo = r[31:0]; end
    if (tail || cancelAt >= 0) begin
      md.start_i = 1'b0; md.cancel_i = 1'b0;
      eStall = 1'b0; eBusy = 1'b0; eDone = 1'b0; eHi = mHi; eLo = mLo;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    md.start_i = 1'b0; md.cancel_i = 1'b0; md.op_i = 2'b00;
    md.a_i = '0; md.b_i = '0;
    mHi = '0; mLo = '0;
    #3;
    chk("rstHi",    64'(md.hi_o),    64'd0);
    chk("rstLo",    64'(md.lo_o),    64'd0);
    chk("rstDone",  64'(md.done_o),  64'd0);
    chk("rstBusy",  64'(md.busy_o),  64'd0);
    chk("rstStall", 64'(md.stall_o), 64'd0);
    md.start_i = 1'b1; #1;
    chk("rstStallStart", 64'(md.stall_o), 64'd1);
    md.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    eStall = 1'b0; eBusy = 1'b0; eDone = 1'b0; eHi = '0; eLo = '0;
    chkEn = 1'b1;
    @(posedge clk); #1;

    runOp(2'b01, 32'hFFFFFFFF, 32'h2, -1, 1'b1, 1'b1, 32'h1, 32'hFFFFFFFE);
    runOp(2'b00, 32'hFFFFFFFD, 32'h5, -1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    runOp(2'b10, 32'hFFFFFFF9, 32'h2, -1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp(2'b11, 32'h7, 32'h2, -1, 1'b1, 1'b1, 32'h1, 32'h3);
    runOp(2'b11, 32'd100, 32'h0, -1, 1'b1, 1'b1, 32'd100, 32'hFFFFFFFF);
    runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, 1'b1, 1'b1, 32'h0, 32'h80000000);
    runOp(2'b10, 32'h7, 32'hFFFFFFFE, -1, 1'b1, 1'b1, 32'h1, 32'hFFFFFFFD);
    runOp(2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, -1, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h2);
    runOp(2'b00, 32'h5, 32'h5, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    runOp(2'b10, 32'd1000, 32'd7, 10, 1'b1, 1'b0, 32'h0, 32'h0);
    runOp(2'b00, 32'h4, 32'h4, -1, 1'b1, 1'b1, 32'h0, 32'd16);

    // Asynchronous reset in the middle of a divide.
    chkEn = 1'b0;
    md.op_i = 2'b11; md.a_i = 32'd50; md.b_i = 32'd3; md.start_i = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("midDivBusy", 64'(md.busy_o), 64'd1);
    #2 rst = 1'b0; md.start_i = 1'b0;
    #1;
    chk("asyncHi",    64'(md.hi_o),    64'd0);
    chk("asyncLo",    64'(md.lo_o),    64'd0);
    chk("asyncDone",  64'(md.done_o),  64'd0);
    chk("asyncBusy",  64'(md.busy_o),  64'd0);
    chk("asyncStall", 64'(md.stall_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    mHi = '0; mLo = '0;
    eStall = 1'b0; eBusy = 1'b0; eDone = 1'b0; eHi = '0; eLo = '0;
    chkEn = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    runOp(2'b11, 32'd100, 32'd7, -1, 1'b1, 1'b1, 32'd2, 32'd14);

    chkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
